// File: rtl/fc_class_pkg.sv
// fc_class_pkg: shared defaults, pipeline depth and FSM state encoding for
// the final classification frame controller and its argmax tree.
// Configuration macro: FC_CLASS_SIGNED_EN (signed score comparison).
package fc_class_pkg;

   // Default frame geometry: ten FC-layer scores of 16 bits each.
   localparam int NUM_CLASS_DEF = 10;
   localparam int DW_DEF        = 16;
   localparam int IW_DEF        = 4;

   // Register stages inside the argmax tree (launch to tree valid).
   localparam int LAT = 3;

   // The tree is built over a fixed 16-leaf footprint; unused leaves are
   // marked absent so they can never win a comparison.
   localparam int TREE_LEAVES = 16;

   // Controller state encoding.
   typedef logic [1:0] state_t;
   localparam state_t COLLECT = 2'd0;
   localparam state_t RUN     = 2'd1;
   localparam state_t DONE    = 2'd2;

endpackage

// File: rtl/fc_class_ctrl_argmax_tree.sv
// class_argmax_tree: pairwise compare tree over NUM_CLASS scores with three
// register stages and a valid bit carried alongside. Ties keep the lower
// index because the right-hand candidate only wins on strictly greater.
// Configuration macro: FC_CLASS_SIGNED_EN selects a two's-complement compare.
module class_argmax_tree
   import fc_class_pkg::*;
#(
   parameter int NUM_CLASS = NUM_CLASS_DEF,
   parameter int DW        = DW_DEF,
   parameter int IW        = IW_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [NUM_CLASS*DW-1:0] in_scores,
   output logic                    out_valid,
   output logic [IW-1:0]           out_index,
   output logic [DW-1:0]           out_value
);

   // Right candidate replaces left only when present and strictly greater.
   function automatic logic right_wins(input logic          l_ok,
                                       input logic [DW-1:0] l_val,
                                       input logic          r_ok,
                                       input logic [DW-1:0] r_val);
      logic gt;
`ifdef FC_CLASS_SIGNED_EN
      gt = $signed(r_val) > $signed(l_val);
`else
      gt = r_val > l_val;
`endif
      return r_ok && (!l_ok || gt);
   endfunction

   logic [TREE_LEAVES*DW-1:0] padded;

   logic [DW-1:0] l0_val [TREE_LEAVES];
   logic [IW-1:0] l0_idx [TREE_LEAVES];
   logic          l0_ok  [TREE_LEAVES];

   logic [DW-1:0] l1_val [8];
   logic [IW-1:0] l1_idx [8];
   logic          l1_ok  [8];

   logic [DW-1:0] l2_val [4];
   logic [IW-1:0] l2_idx [4];
   logic          l2_ok  [4];

   logic [DW-1:0] s1_val [4];
   logic [IW-1:0] s1_idx [4];
   logic          s1_ok  [4];

   logic [DW-1:0] l3_val [2];
   logic [IW-1:0] l3_idx [2];
   logic          l3_ok  [2];

   logic [DW-1:0] s2_val [2];
   logic [IW-1:0] s2_idx [2];
   logic          s2_ok  [2];

   logic [LAT-1:0] vld_pipe;

   assign padded = (TREE_LEAVES*DW)'(in_scores);

   // Spread the flat score bus into leaves, flagging leaves beyond NUM_CLASS.
   always_comb begin
      for (int i = 0; i < TREE_LEAVES; i++) begin
         l0_val[i] = padded[i*DW +: DW];
         l0_idx[i] = IW'(i);
         l0_ok[i]  = (i < NUM_CLASS);
      end
   end

   // First two compare levels (16 -> 8 -> 4) ahead of the first register.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         if (right_wins(l0_ok[2*i], l0_val[2*i], l0_ok[2*i+1], l0_val[2*i+1])) begin
            l1_val[i] = l0_val[2*i+1];
            l1_idx[i] = l0_idx[2*i+1];
         end else begin
            l1_val[i] = l0_val[2*i];
            l1_idx[i] = l0_idx[2*i];
         end
         l1_ok[i] = l0_ok[2*i] | l0_ok[2*i+1];
      end
      for (int i = 0; i < 4; i++) begin
         if (right_wins(l1_ok[2*i], l1_val[2*i], l1_ok[2*i+1], l1_val[2*i+1])) begin
            l2_val[i] = l1_val[2*i+1];
            l2_idx[i] = l1_idx[2*i+1];
         end else begin
            l2_val[i] = l1_val[2*i];
            l2_idx[i] = l1_idx[2*i];
         end
         l2_ok[i] = l1_ok[2*i] | l1_ok[2*i+1];
      end
   end

   // Stage 1 register: four surviving candidates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            s1_val[i] <= '0;
            s1_idx[i] <= '0;
            s1_ok[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            s1_val[i] <= l2_val[i];
            s1_idx[i] <= l2_idx[i];
            s1_ok[i]  <= l2_ok[i];
         end
      end
   end

   // Third compare level (4 -> 2).
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         if (right_wins(s1_ok[2*i], s1_val[2*i], s1_ok[2*i+1], s1_val[2*i+1])) begin
            l3_val[i] = s1_val[2*i+1];
            l3_idx[i] = s1_idx[2*i+1];
         end else begin
            l3_val[i] = s1_val[2*i];
            l3_idx[i] = s1_idx[2*i];
         end
         l3_ok[i] = s1_ok[2*i] | s1_ok[2*i+1];
      end
   end

   // Stage 2 register: two surviving candidates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            s2_val[i] <= '0;
            s2_idx[i] <= '0;
            s2_ok[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            s2_val[i] <= l3_val[i];
            s2_idx[i] <= l3_idx[i];
            s2_ok[i]  <= l3_ok[i];
         end
      end
   end

   // Stage 3 register: final compare (2 -> 1) lands directly in the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_index <= '0;
         out_value <= '0;
      end else if (right_wins(s2_ok[0], s2_val[0], s2_ok[1], s2_val[1])) begin
         out_index <= s2_idx[1];
         out_value <= s2_val[1];
      end else begin
         out_index <= s2_idx[0];
         out_value <= s2_val[0];
      end
   end

   // Valid shadow pipeline; reset flushes any launch in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
      end
   end

   assign out_valid = vld_pipe[LAT-1];

endmodule

// File: rtl/fc_class_ctrl.sv
// fc_class_ctrl: collects one frame of FC-layer scores from a valid/ready
// stream, runs a pipelined argmax over the buffered frame and presents the
// winning class index and score with a valid/ready handshake.
// Configuration macro: FC_CLASS_SIGNED_EN (signed score comparison).
module fc_class_ctrl
   import fc_class_pkg::*;
#(
   parameter int NUM_CLASS = NUM_CLASS_DEF,
   parameter int DW        = DW_DEF,
   parameter int IW        = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_index,
   output logic [DW-1:0] out_value,
   output logic          busy,
   output logic          err_len
);

   localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_CLASS - 1);

   state_t                  state;
   logic [IW-1:0]           cnt;
   logic [NUM_CLASS*DW-1:0] scores;
   logic                    run_first;
   logic                    launch;
   logic                    accept;
   logic                    tree_valid;
   logic [IW-1:0]           tree_index;
   logic [DW-1:0]           tree_value;

   assign in_ready = (state == COLLECT) && !rst;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != COLLECT) || (cnt != '0);

   // Score buffer: each accepted beat lands in the slot for its class.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scores <= '0;
      end else if (accept) begin
         scores[int'(cnt)*DW +: DW] <= in_data;
      end
   end

   // Frame FSM, beat counter, launch pulse, error pulse and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         cnt       <= '0;
         run_first <= 1'b0;
         launch    <= 1'b0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_value <= '0;
         err_len   <= 1'b0;
      end else begin
         err_len   <= 1'b0;
         run_first <= 1'b0;
         launch    <= run_first;
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (cnt == LAST_SLOT) begin
                     cnt       <= '0;
                     state     <= RUN;
                     run_first <= 1'b1;
                     err_len   <= !in_last;
                  end else if (in_last) begin
                     cnt     <= '0;
                     err_len <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (tree_valid) begin
                  out_index <= tree_index;
                  out_value <= tree_value;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= COLLECT;
               end
            end
            default: begin
               state <= COLLECT;
            end
         endcase
      end
   end

   class_argmax_tree #(
      .NUM_CLASS (NUM_CLASS),
      .DW        (DW),
      .IW        (IW)
   ) u_tree (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (launch),
      .in_scores (scores),
      .out_valid (tree_valid),
      .out_index (tree_index),
      .out_value (tree_value)
   );

endmodule

// File: tb/tb_fc_class_ctrl.sv
// tb_fc_class_ctrl: directed self-checking bench for fc_class_ctrl.
// Honors FC_CLASS_SIGNED_EN for the signed/unsigned compare vector.
module tb_fc_class_ctrl;

   localparam int NC = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_index;
   logic [DW-1:0] out_value;
   logic          busy;
   logic          err_len;

   int n_assert   = 0;
   int n_fail     = 0;
   int cyc        = 0;
   int t_beat     = 0;
   int err_pulses = 0;

   fc_class_ctrl #(.NUM_CLASS(NC), .DW(DW), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_value (out_value),
      .busy      (busy),
      .err_len   (err_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (err_len === 1'b1) err_pulses++;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      t_beat   = cyc;
   endtask

   task automatic sendFrame(input logic [DW-1:0] f [NC], input int first, input int last_pos);
      int stop;
      stop = (last_pos >= 0) ? last_pos : NC - 1;
      for (int i = first; i <= stop; i++) applyStimulus(f[i], (i == last_pos));
   endtask

   task automatic waitResult(output int lat);
      int guard = 0;
      while (out_valid !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) checkOutput("out_valid_timeout", 32'd0, 32'd1);
      lat = cyc - t_beat;
   endtask

   initial begin
      logic [DW-1:0] f [NC];
      int lat;
      int err_before;
      int seen_valid;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", {out_valid, in_ready, busy, err_len, out_index, out_value},
                  32'd0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", in_ready, 1'b1);

      // Ascending scores, in_last on the tenth beat.
      $display("[TB] ascending frame");
      f = '{16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700, 16'd800, 16'd900};
      err_before = err_pulses;
      sendFrame(f, 0, 9);
      checkOutput("busy_in_run", busy, 1'b1);
      waitResult(lat);
      checkOutput("asc_latency", lat, 32'd5);
      checkOutput("asc_index", out_index, 32'd9);
      checkOutput("asc_value", out_value, 32'd900);
      checkOutput("asc_no_err", err_pulses - err_before, 32'd0);
      @(posedge clk); #1;
      checkOutput("asc_handshake", {out_valid, in_ready}, 2'b01);

      // All scores equal and no in_last: tie picks class 0, err_len pulses once.
      $display("[TB] equal frame without in_last");
      for (int i = 0; i < NC; i++) f[i] = 16'h0050;
      err_before = err_pulses;
      sendFrame(f, 0, -1);
      waitResult(lat);
      checkOutput("tie_index", out_index, 32'd0);
      checkOutput("tie_value", out_value, 32'h0050);
      checkOutput("tie_err_pulse", err_pulses - err_before, 32'd1);
      checkOutput("tie_err_not_with_valid", err_len, 1'b0);
      @(posedge clk); #1;

      // Sign test: class 5 = 0x8000, others 0x0001.
      $display("[TB] signedness frame");
      for (int i = 0; i < NC; i++) f[i] = 16'h0001;
      f[5] = 16'h8000;
      sendFrame(f, 0, 9);
      waitResult(lat);
`ifdef FC_CLASS_SIGNED_EN
      checkOutput("sign_index", out_index, 32'd0);
      checkOutput("sign_value", out_value, 32'h0001);
`else
      checkOutput("sign_index", out_index, 32'd5);
      checkOutput("sign_value", out_value, 32'h8000);
`endif
      @(posedge clk); #1;

      // Backpressure: out_ready low for 6 cycles while upstream pushes.
      $display("[TB] backpressure frame");
      out_ready = 1'b0;
      f = '{16'h0100, 16'h0200, 16'h0050, 16'h0777, 16'h0001,
            16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
      sendFrame(f, 0, 9);
      waitResult(lat);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_stable", {out_valid, in_ready, out_index, out_value},
                     {1'b1, 1'b0, 4'd3, 16'h0777});
      end
      f = '{16'h0011, 16'h0022, 16'h0AAA, 16'h0033, 16'h0044,
            16'h0055, 16'h0066, 16'h0077, 16'h0088, 16'h0099};
      in_data   = f[0];
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_handshake", {out_valid, in_ready, busy}, 3'b010);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp_first_beat_taken", busy, 1'b1);
      sendFrame(f, 1, 9);
      waitResult(lat);
      checkOutput("bp_next_index", out_index, 32'd2);
      checkOutput("bp_next_value", out_value, 32'h0AAA);
      @(posedge clk); #1;

      // Early in_last on beat 4, then a clean frame with class 7 maximum.
      $display("[TB] early last frame");
      f = '{16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      sendFrame(f, 0, 3);
      checkOutput("early_err_pulse", {err_len, busy}, 2'b10);
      seen_valid = 0;
      @(posedge clk); #1;
      checkOutput("early_err_one_cycle", err_len, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (out_valid === 1'b1) seen_valid++;
         @(posedge clk); #1;
      end
      checkOutput("early_no_valid", seen_valid, 32'd0);
      f = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
            16'h0600, 16'h0700, 16'h1234, 16'h0800, 16'h0900};
      sendFrame(f, 0, 9);
      waitResult(lat);
      checkOutput("after_early_index", out_index, 32'd7);
      checkOutput("after_early_value", out_value, 32'h1234);
      @(posedge clk); #1;

      // Reset two cycles after the final beat aborts the frame.
      $display("[TB] reset mid run");
      f = '{16'h0009, 16'h0008, 16'h0007, 16'h0006, 16'h0005,
            16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
      sendFrame(f, 0, 9);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_outputs", {out_valid, in_ready, busy, err_len, out_index, out_value},
                  32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checkOutput("abort_ready", {in_ready, busy}, 2'b10);
      seen_valid = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen_valid++;
      end
      checkOutput("abort_no_valid", seen_valid, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
